// File: rtl/seg7_bin_display_if.sv
// -----------------------------------------------------------------------------
// seg7_bin_display_if
//   Load handshake between a producer and seg7_bin_display.
//   valid_in  : load request, qualifies data_in and hex_mode
//   data_in   : WIDTH-bit unsigned binary value
//   hex_mode  : 1 = hexadecimal digits, 0 = decimal digits
//   ready     : consumer idle; a load is accepted on valid_in & ready
// -----------------------------------------------------------------------------
interface seg7_bin_display_if #(
   parameter int WIDTH = 9
);
   logic             valid_in;
   logic [WIDTH-1:0] data_in;
   logic             hex_mode;
   logic             ready;

   modport master (output valid_in, data_in, hex_mode, input ready);
   modport slave  (input valid_in, data_in, hex_mode, output ready);
endinterface

// File: rtl/seg7_bin_display.sv
// -----------------------------------------------------------------------------
// seg7_bin_display
//   Multi-digit seven-segment driver. A WIDTH-bit binary word is accepted over
//   the bus handshake and either converted to decimal by an iterative
//   shift-add-3 engine (one bit per cycle) or split straight into hex nibbles.
//   The result is registered onto DIGITS segment fields in a single LOAD cycle.
//
//   Parameters : WIDTH (>=4), DIGITS (>=1), SEG_ACTIVE_LOW (1 inverts outputs)
//   Ports      : clk, rst     - clock, synchronous active-high reset
//                bus          - slave side of seg7_bin_display_if
//                seg_out      - digit k in [7k+6:7k], bit 6 = g .. bit 0 = a
//                overflow     - last accepted value did not fit in DIGITS
//   Build option: SEG7_LZB_EN - blank leading zero digits in decimal mode
// -----------------------------------------------------------------------------
module seg7_bin_display #(
   parameter int WIDTH          = 9,
   parameter int DIGITS         = 3,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   seg7_bin_display_if.slave       bus,
   output logic [7*DIGITS-1:0]     seg_out,
   output logic                    overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [7*DIGITS-1:0] SEG_BLANK =
      (SEG_ACTIVE_LOW != 0) ? {7*DIGITS{1'b1}} : '0;
   localparam logic [6:0] DASH = 7'b1000000;

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [BW-1:0]        bcd_q, bcd_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;     // sticky overflow of the current job
   logic                 hex_q, hex_d;
   logic [7*DIGITS-1:0]  seg_q, seg_d;
   logic                 ovfo_q, ovfo_d;   // overflow as shown to the outside

   logic [BW-1:0]        hex_nib;
   logic                 hex_ovf;
   logic [BW-1:0]        bcd_adj;
   logic [DIGITS-1:0]    blank_mask;
   logic [7*DIGITS-1:0]  seg_raw;

   function automatic logic [6:0] enc(input logic [3:0] n);
      case (n)
         4'h0: enc = 7'b0111111;
         4'h1: enc = 7'b0000110;
         4'h2: enc = 7'b1011011;
         4'h3: enc = 7'b1001111;
         4'h4: enc = 7'b1100110;
         4'h5: enc = 7'b1101101;
         4'h6: enc = 7'b1111101;
         4'h7: enc = 7'b0000111;
         4'h8: enc = 7'b1111111;
         4'h9: enc = 7'b1101111;
         4'hA: enc = 7'b1110111;
         4'hB: enc = 7'b1111100;
         4'hC: enc = 7'b0111001;
         4'hD: enc = 7'b1011110;
         4'hE: enc = 7'b1111001;
         default: enc = 7'b1110001;
      endcase
   endfunction

   // Hex capture: low nibbles go straight into the digit register; any set
   // bit above the displayable nibbles is an overflow.
   generate
      if (WIDTH > BW) begin : g_hex_wide
         assign hex_nib = bus.data_in[BW-1:0];
         assign hex_ovf = |bus.data_in[WIDTH-1:BW];
      end else begin : g_hex_narrow
         assign hex_nib = BW'(bus.data_in);
         assign hex_ovf = 1'b0;
      end
   endgenerate

   // Add-3 correction applied before each shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5)
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
   end

`ifdef SEG7_LZB_EN
   // Blank zeros from the top digit down to the first nonzero one; digit 0
   // always shows. Hex results are never blanked.
   always_comb begin : lzb_scan
      logic lead;
      lead       = !hex_q;
      blank_mask = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (lead && (bcd_q[4*k +: 4] == 4'd0))
            blank_mask[k] = 1'b1;
         else
            lead = 1'b0;
      end
   end
`else
   assign blank_mask = '0;
`endif

   always_comb begin
      seg_raw = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (ovf_q)
            seg_raw[7*k +: 7] = DASH;
         else if (blank_mask[k])
            seg_raw[7*k +: 7] = 7'b0000000;
         else
            seg_raw[7*k +: 7] = enc(bcd_q[4*k +: 4]);
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      hex_d   = hex_q;
      seg_d   = seg_q;
      ovfo_d  = ovfo_q;
      case (state_q)
         IDLE: begin
            if (bus.valid_in) begin
               hex_d = bus.hex_mode;
               if (bus.hex_mode) begin
                  bcd_d   = hex_nib;
                  ovf_d   = hex_ovf;
                  state_d = LOAD;
               end else begin
                  data_d  = bus.data_in;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            // {bcd, data} <<= 1 after correction; a bit leaving the BCD
            // MSB means the value needs more digits than we have.
            bcd_d  = {bcd_adj[BW-2:0], data_q[WIDTH-1]};
            data_d = {data_q[WIDTH-2:0], 1'b0};
            ovf_d  = ovf_q | bcd_adj[BW-1];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1))
               state_d = LOAD;
         end
         LOAD: begin
            seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
            ovfo_d  = ovf_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         hex_q   <= 1'b0;
         seg_q   <= SEG_BLANK;
         ovfo_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         hex_q   <= hex_d;
         seg_q   <= seg_d;
         ovfo_q  <= ovfo_d;
      end
   end

   // Held low while reset is asserted so nothing is accepted during reset.
   assign bus.ready = (state_q == IDLE) && !rst;
   assign seg_out   = seg_q;
   assign overflow  = ovfo_q;

endmodule

// File: tb/tb_seg7_bin_display.sv
module tb_seg7_bin_display;

   localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                          S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                          S7 = 7'b0000111, S9 = 7'b1101111, SA = 7'b1110111,
                          SF = 7'b1110001, BLK = 7'b0000000, DASH = 7'b1000000;
`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_bin_display_if #(.WIDTH(9)) if0 ();
   seg7_bin_display_if #(.WIDTH(9)) if1 ();
   seg7_bin_display_if #(.WIDTH(9)) if2 ();

   logic [20:0] seg0, seg1;
   logic [13:0] seg2;
   logic        ovf0, ovf1, ovf2;

   seg7_bin_display #(.WIDTH(9), .DIGITS(3), .SEG_ACTIVE_LOW(0)) u0 (
      .clk(clk), .rst(rst), .bus(if0), .seg_out(seg0), .overflow(ovf0));
   seg7_bin_display #(.WIDTH(9), .DIGITS(3), .SEG_ACTIVE_LOW(1)) u1 (
      .clk(clk), .rst(rst), .bus(if1), .seg_out(seg1), .overflow(ovf1));
   seg7_bin_display #(.WIDTH(9), .DIGITS(2), .SEG_ACTIVE_LOW(0)) u2 (
      .clk(clk), .rst(rst), .bus(if2), .seg_out(seg2), .overflow(ovf2));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a request on u0 for one edge (accepted if ready=1).
   task automatic req0(input logic [8:0] d, input logic h);
      if0.valid_in = 1'b1; if0.data_in = d; if0.hex_mode = h;
      tick();
      if0.valid_in = 1'b0;
   endtask

   task automatic req2(input logic [8:0] d, input logic h);
      if2.valid_in = 1'b1; if2.data_in = d; if2.hex_mode = h;
      tick();
      if2.valid_in = 1'b0;
   endtask

   initial begin
      int          lat, rdy_at;
      logic [20:0] prev, exp21;

      rst = 1'b1;
      if0.valid_in = 1'b0; if0.data_in = '0; if0.hex_mode = 1'b0;
      if1.valid_in = 1'b0; if1.data_in = '0; if1.hex_mode = 1'b0;
      if2.valid_in = 1'b0; if2.data_in = '0; if2.hex_mode = 1'b0;
      @(negedge clk);
      repeat (3) tick();

      // Reset state
      check("rst_seg0", seg0, 21'h0);
      check("rst_ovf0", ovf0, 0);
      check("rst_ready0", if0.ready, 0);
      check("rst_seg1_activelow", seg1, 21'h1FFFFF);
      check("rst_seg2", seg2, 14'h0);
      rst = 1'b0;
      tick();
      check("ready_after_rst", if0.ready, 1);

      // Decimal 255: latency to the display edge and to ready
      req0(9'd255, 1'b0);
      lat = 0; rdy_at = 0;
      for (int i = 1; i <= 12; i++) begin
         prev = seg0;
         tick();
         if (lat == 0 && seg0 !== prev) lat = i;
         if (rdy_at == 0 && if0.ready === 1'b1) rdy_at = i;
      end
      check("dec255_latency", lat, 10);
      check("dec255_ready_at", rdy_at, 10);
      check("dec255_seg", seg0, {S2, S5, S5});
      check("dec255_ovf", ovf0, 0);

      // Hex 1AF: one cycle after accept
      req0(9'h1AF, 1'b1);
      check("hex1af_hold", seg0, {S2, S5, S5});
      check("hex1af_busy", if0.ready, 0);
      tick();
      check("hex1af_seg", seg0, {S1, SA, SF});
      check("hex1af_ready", if0.ready, 1);
      check("hex1af_ovf", ovf0, 0);

      // Active-low hex 00F
      if1.valid_in = 1'b1; if1.data_in = 9'h00F; if1.hex_mode = 1'b1;
      tick();
      if1.valid_in = 1'b0;
      tick();
      check("hex00f_low", seg1, {7'b1000000, 7'b1000000, 7'b0001110});
      check("hex00f_low_ovf", ovf1, 0);

      // Two digits: decimal 100 overflows, 99 fits
      req2(9'd100, 1'b0);
      repeat (10) tick();
      check("d2_100_seg", seg2, {DASH, DASH});
      check("d2_100_ovf", ovf2, 1);
      req2(9'd99, 1'b0);
      repeat (10) tick();
      check("d2_99_seg", seg2, {S9, S9});
      check("d2_99_ovf", ovf2, 0);
      // Hex overflow boundary: bit 8 set with only 8 displayable bits
      req2(9'h100, 1'b1);
      tick();
      check("d2_hex100_seg", seg2, {DASH, DASH});
      check("d2_hex100_ovf", ovf2, 1);
      req2(9'h0FF, 1'b1);
      tick();
      check("d2_hexff_seg", seg2, {SF, SF});
      check("d2_hexff_ovf", ovf2, 0);

      // Leading zeros
      req0(9'd7, 1'b0);
      repeat (10) tick();
      exp21 = LZB ? {BLK, BLK, S7} : {S0, S0, S7};
      check("dec7_seg", seg0, exp21);
      req0(9'd0, 1'b0);
      repeat (10) tick();
      exp21 = LZB ? {BLK, BLK, S0} : {S0, S0, S0};
      check("dec0_seg", seg0, exp21);

      // Request while busy is dropped
      req0(9'd123, 1'b0);
      repeat (2) tick();
      if0.valid_in = 1'b1; if0.data_in = 9'd456; if0.hex_mode = 1'b0;
      tick();
      if0.valid_in = 1'b0;
      check("drop_busy_ready", if0.ready, 0);
      repeat (6) tick();
      check("drop_t9_ready", if0.ready, 0);
      tick();
      check("drop_t10_seg", seg0, {S1, S2, S3});
      check("drop_t10_ready", if0.ready, 1);
      repeat (12) tick();
      check("drop_no_second", seg0, {S1, S2, S3});

      // Reset mid-conversion
      req0(9'd42, 1'b0);
      repeat (10) tick();
      exp21 = LZB ? {BLK, S4, S2} : {S0, S4, S2};
      check("dec42_seg", seg0, exp21);
      req0(9'd300, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("abort_seg0", seg0, 21'h0);
      check("abort_ovf0", ovf0, 0);
      check("abort_ready0", if0.ready, 0);
      check("abort_seg1", seg1, 21'h1FFFFF);
      rst = 1'b0;
      tick();
      check("abort_ready_after", if0.ready, 1);
      repeat (12) tick();
      check("abort_no_late_write", seg0, 21'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
